slave: RTL and testbench



---
 rtl/slave.sv | 137 +++++++++++++
 tb/tb_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/slave.sv
// Serial bus slave: deserialises address and write data into a byte memory
// and serialises read data back to the master, with incrementing bursts.
module slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic read_en,
  input  logic burst_mode,
  input  logic addr_rx,
  input  logic data_rx,
  output logic slave_ready,
  output logic slave_valid,
  output logic data_tx
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RFETCH, RDATA
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd;
  logic                  r_burst;
  logic [DATA_WIDTH-1:0] r_wdat;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_ready;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  logic w_addr_done;
  logic w_data_done;
  logic w_tx_done;

  assign w_addr_done = valid && (r_cnt == A_LAST);
  assign w_data_done = valid && (r_cnt == D_LAST);
  assign w_tx_done   = (r_cnt == D_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (valid) w_next = ADDR;
      ADDR:    if (w_addr_done) w_next = r_rd ? RFETCH : WDATA;
      WDATA:   if (w_data_done) w_next = WRITE;
      WRITE:   w_next = r_burst ? WDATA : IDLE;
      RFETCH:  w_next = RDATA;
      RDATA:   if (w_tx_done) w_next = burst_mode ? RFETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Address and write data enter at the MSB so LSB-first bits land in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_burst <= 1'b0;
      r_wdat  <= '0;
      r_tx    <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ready <= (w_next == WDATA);
      r_valid <= (w_next == RDATA);
      unique case (r_state)
        IDLE: begin
          if (valid) begin
            r_addr <= {addr_rx, r_addr[ADDR_WIDTH-1:1]};
            r_rd   <= read_en;
            r_cnt  <= CW'(1);
          end
        end
        ADDR: begin
          if (valid) begin
            r_addr <= {addr_rx, r_addr[ADDR_WIDTH-1:1]};
            r_cnt  <= w_addr_done ? '0 : r_cnt + 1'b1;
          end
        end
        WDATA: begin
          if (valid) begin
            r_wdat <= {data_rx, r_wdat[DATA_WIDTH-1:1]};
            if (w_data_done) begin
              r_burst <= burst_mode;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (r_burst) r_addr <= r_addr + 1'b1;
        end
        RFETCH: begin
          r_tx  <= r_mem[r_addr];
          r_cnt <= '0;
        end
        RDATA: begin
          r_tx <= r_tx >> 1;
          if (w_tx_done) begin
            r_cnt <= '0;
            if (burst_mode) r_addr <= r_addr + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Memory survives reset; a reset forces IDLE so no commit can follow it.
  always_ff @(posedge clock) begin
    if (r_state == WRITE) r_mem[r_addr] <= r_wdat;
  end

  assign slave_ready = r_ready;
  assign slave_valid = r_valid;
  assign data_tx     = r_tx[0];

endmodule

// File: tb/tb_slave.sv
// Directed bench for the serial bus slave: writes, reads, stalls,
// wrapping bursts, asynchronous reset and ignored inputs.
module tb_slave;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic read_en = 1'b0;
  logic burst_mode = 1'b0;
  logic addr_rx = 1'b0;
  logic data_rx = 1'b0;
  logic slave_ready;
  logic slave_valid;
  logic data_tx;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] q;

  slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .read_en     (read_en),
    .burst_mode  (burst_mode),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .data_tx     (data_tx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_addr(input logic [11:0] a, input bit rd,
                           input int stall_at, input int stall_n);
    for (int i = 0; i < AW; i++) begin
      @(negedge clock);
      valid   = 1'b1;
      addr_rx = a[i];
      read_en = (i == 0) ? rd : ~rd;
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clock);
          valid   = 1'b0;
          addr_rx = ~a[i];
          read_en = ~rd;
        end
      end
    end
  endtask

  task automatic write_txn(input logic [11:0] a, input logic [23:0] d,
                           input int n, input int ds_at, input int ds_n);
    int rdy;
    rdy = 0;
    send_addr(a, 1'b0, -1, 0);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < DW; i++) begin
        @(negedge clock);
        rdy        += int'(slave_ready);
        valid      = 1'b1;
        data_rx    = d[b*8+i];
        burst_mode = (b < n - 1) && (i == DW - 1);
        if (b == 0 && i == ds_at) begin
          for (int s = 0; s < ds_n; s++) begin
            @(negedge clock);
            rdy    += int'(slave_ready);
            valid   = 1'b0;
            data_rx = ~data_rx;
          end
        end
      end
      @(negedge clock);
      chk("wr_gap_ready", slave_ready, 0);
      valid      = 1'b0;
      burst_mode = 1'b0;
    end
    @(negedge clock);
    chk("wr_end_ready", slave_ready, 0);
    chk("wr_ready_cycles", rdy, 8 * n + ds_n);
  endtask

  task automatic read_txn(input logic [11:0] a, input int n,
                          input bit noise, output logic [23:0] rq);
    int vc;
    rq = '0;
    send_addr(a, 1'b1, -1, 0);
    @(negedge clock);
    valid = 1'b0;
    chk("rd_fetch_valid", slave_valid, 0);
    for (int b = 0; b < n; b++) begin
      vc = 0;
      for (int i = 0; i < DW; i++) begin
        @(negedge clock);
        rq[b*8+i]  = data_tx;
        vc        += int'(slave_valid);
        burst_mode = (b < n - 1) && (i == DW - 1);
        if (noise) begin
          valid   = 1'($urandom);
          data_rx = 1'($urandom);
          addr_rx = 1'($urandom);
        end
      end
      @(negedge clock);
      chk("rd_gap_valid_tx", {slave_valid, data_tx}, 0);
      valid      = 1'b0;
      burst_mode = 1'b0;
      chk("rd_valid_cycles", vc, 8);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("idle_outputs", {slave_ready, slave_valid, data_tx}, 0);
    end

    write_txn(12'hCB2, 24'h0000D5, 1, 3, 2);
    read_txn(12'hCB2, 1, 1'b0, q);
    chk("rd_cb2", q[7:0], 8'hD5);

    write_txn(12'h015, 24'h0000A7, 1, -1, 0);
    send_addr(12'h005, 1'b0, 4, 3);
    for (int i = 0; i < DW; i++) begin
      @(negedge clock);
      valid   = 1'b1;
      data_rx = (8'h3C >> i) & 1'b1;
    end
    @(negedge clock);
    valid = 1'b0;
    @(negedge clock);
    read_txn(12'h005, 1, 1'b0, q);
    chk("rd_005", q[7:0], 8'h3C);
    read_txn(12'h015, 1, 1'b0, q);
    chk("rd_015", q[7:0], 8'hA7);

    write_txn(12'hFFF, 24'h332211, 3, -1, 0);
    read_txn(12'hFFF, 1, 1'b0, q);
    chk("rd_fff", q[7:0], 8'h11);
    read_txn(12'h000, 1, 1'b0, q);
    chk("rd_000", q[7:0], 8'h22);
    read_txn(12'h001, 1, 1'b0, q);
    chk("rd_001", q[7:0], 8'h33);
    read_txn(12'hFFF, 3, 1'b0, q);
    chk("burst_rd", q, 24'h332211);

    write_txn(12'h100, 24'h00005A, 1, -1, 0);
    send_addr(12'h100, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      valid   = 1'b1;
      data_rx = 1'b1;
    end
    @(negedge clock);
    chk("pre_reset_ready", slave_ready, 1);
    #2 reset = 1'b1;
    #1 chk("reset_wr_outputs", {slave_ready, slave_valid, data_tx}, 0);
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    read_txn(12'h100, 1, 1'b0, q);
    chk("rd_100", q[7:0], 8'h5A);

    send_addr(12'hCB2, 1'b1, -1, 0);
    @(negedge clock);
    valid = 1'b0;
    @(negedge clock);
    chk("pre_reset_rd", {slave_valid, data_tx}, 2'b11);
    #2 reset = 1'b1;
    #1 chk("reset_rd_outputs", {slave_ready, slave_valid, data_tx}, 0);
    @(negedge clock);
    reset = 1'b0;

    read_txn(12'hCB2, 1, 1'b1, q);
    chk("rd_noise", q[7:0], 8'hD5);
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("post_noise_idle", {slave_ready, slave_valid}, 0);
    end
    read_txn(12'hCB2, 1, 1'b0, q);
    chk("rd_after_noise", q[7:0], 8'hD5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
